// File: rtl/i2c_codec_responder.sv
// I2C responder standing in for the CODEC register file: 7-bit register address,
// 9-bit data carried in two-byte frames, with a commit strobe and a backdoor read port.
module i2c_codec_responder #(
    parameter logic [6:0] DEVICE_ADDR = 7'h1A,
    parameter int         NUM_REGS    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl_i,
    input  logic       i2c_sda_i,
    output logic       i2c_sda_o,
    output logic       i2c_sda_t,
    output logic       reg_wr_strobe,
    output logic [6:0] reg_wr_addr,
    output logic [8:0] reg_wr_data,
    input  logic [6:0] dbg_rd_addr,
    output logic [8:0] dbg_rd_data,
    output logic       busy
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, BYTE1, ACK1, BYTE2, ACK2, RD_BYTE, RD_MACK, IGNORE
    } state_t;

    state_t     state, state_n;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d, scl, sda;
    logic       scl_rise, scl_fall, start_c, stop_c, byte_done, rx_state;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [6:0] tx, tx_n;
    logic [6:0] ptr, ptr_n;
    logic       data_hi, data_hi_n, rw, rw_n, cont, cont_n;
    logic       rd_lo, rd_lo_n, mack, mack_n;
    logic       sda_t_n, busy_n, strobe_n;
    logic [6:0] wr_addr_n;
    logic [8:0] wr_data_n;
    logic [8:0] regs [NUM_REGS];
    logic [8:0] ptr_word;
    logic [7:0] hi_byte, lo_byte;

    function automatic logic in_range(input logic [6:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    assign i2c_sda_o = 1'b0;

    assign scl       = scl_sync[1];
    assign sda       = sda_sync[1];
    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    assign start_c   = scl & scl_d & sda_d & ~sda;
    assign stop_c    = scl & scl_d & ~sda_d & sda;
    assign byte_done = scl_fall && (cnt == 4'd8);
    assign rx_state  = (state == DEV_ADDR) || (state == BYTE1) || (state == BYTE2);

    assign ptr_word    = in_range(ptr) ? regs[ptr[AW-1:0]] : 9'h000;
    assign hi_byte     = {7'b0, ptr_word[8]};
    assign lo_byte     = ptr_word[7:0];
    assign dbg_rd_data = in_range(dbg_rd_addr) ? regs[dbg_rd_addr[AW-1:0]] : 9'h000;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        tx_n      = tx;
        ptr_n     = ptr;
        data_hi_n = data_hi;
        rw_n      = rw;
        cont_n    = cont;
        rd_lo_n   = rd_lo;
        mack_n    = mack;
        sda_t_n   = i2c_sda_t;
        busy_n    = busy;
        strobe_n  = 1'b0;
        wr_addr_n = reg_wr_addr;
        wr_data_n = reg_wr_data;
        if (stop_c) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            sda_t_n = 1'b1;
        end else if (start_c) begin
            state_n = DEV_ADDR;
            cnt_n   = '0;
            sda_t_n = 1'b1;
        end else begin
            if (rx_state && scl_rise && cnt != 4'd8) begin
                shreg_n = {shreg[6:0], sda};
                cnt_n   = cnt + 4'd1;
            end
            case (state)
                DEV_ADDR: if (byte_done) begin
                    cnt_n = '0;
                    if (shreg[7:1] == DEVICE_ADDR) begin
                        state_n = DEV_ACK;
                        sda_t_n = 1'b0;
                        busy_n  = 1'b1;
                        rw_n    = shreg[0];
                        cont_n  = 1'b0;
                    end else begin
                        state_n = IGNORE;
                    end
                end
                DEV_ACK: if (scl_fall) begin
                    cnt_n = '0;
                    if (rw) begin
                        state_n = RD_BYTE;
                        rd_lo_n = 1'b0;
                        tx_n    = hi_byte[6:0];
                        sda_t_n = hi_byte[7];
                    end else begin
                        state_n = BYTE1;
                        sda_t_n = 1'b1;
                    end
                end
                // Continuation pairs advance the pointer; a first pair loads it.
                BYTE1: if (byte_done) begin
                    cnt_n     = '0;
                    state_n   = ACK1;
                    sda_t_n   = 1'b0;
                    ptr_n     = cont ? ptr + 7'd1 : shreg[7:1];
                    data_hi_n = shreg[0];
                end
                ACK1: if (scl_fall) begin
                    state_n = BYTE2;
                    sda_t_n = 1'b1;
                end
                BYTE2: if (byte_done) begin
                    cnt_n   = '0;
                    state_n = ACK2;
                    sda_t_n = 1'b0;
                end
                ACK2: begin
                    if (scl_rise) begin
                        strobe_n  = 1'b1;
                        wr_addr_n = ptr;
                        wr_data_n = {data_hi, shreg};
                    end
                    if (scl_fall) begin
                        state_n = BYTE1;
                        sda_t_n = 1'b1;
                        cont_n  = 1'b1;
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) cnt_n = cnt + 4'd1;
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            state_n = RD_MACK;
                            sda_t_n = 1'b1;
                        end else begin
                            sda_t_n = tx[6];
                            tx_n    = {tx[5:0], 1'b0};
                        end
                    end
                end
                // Pointer advances on the master ACK so the next byte sees the new word.
                RD_MACK: begin
                    if (scl_rise) begin
                        mack_n = ~sda;
                        if (~sda && rd_lo) ptr_n = ptr + 7'd1;
                    end
                    if (scl_fall) begin
                        if (mack) begin
                            state_n = RD_BYTE;
                            cnt_n   = '0;
                            rd_lo_n = ~rd_lo;
                            if (rd_lo) begin
                                tx_n    = hi_byte[6:0];
                                sda_t_n = hi_byte[7];
                            end else begin
                                tx_n    = lo_byte[6:0];
                                sda_t_n = lo_byte[7];
                            end
                        end else begin
                            state_n = IGNORE;
                            sda_t_n = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync      <= 2'b11;
            sda_sync      <= 2'b11;
            scl_d         <= 1'b1;
            sda_d         <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            shreg         <= '0;
            tx            <= '0;
            ptr           <= '0;
            data_hi       <= 1'b0;
            rw            <= 1'b0;
            cont          <= 1'b0;
            rd_lo         <= 1'b0;
            mack          <= 1'b0;
            i2c_sda_t     <= 1'b1;
            busy          <= 1'b0;
            reg_wr_strobe <= 1'b0;
            reg_wr_addr   <= '0;
            reg_wr_data   <= '0;
        end else begin
            scl_sync      <= {scl_sync[0], i2c_scl_i};
            sda_sync      <= {sda_sync[0], i2c_sda_i};
            scl_d         <= scl_sync[1];
            sda_d         <= sda_sync[1];
            state         <= state_n;
            cnt           <= cnt_n;
            shreg         <= shreg_n;
            tx            <= tx_n;
            ptr           <= ptr_n;
            data_hi       <= data_hi_n;
            rw            <= rw_n;
            cont          <= cont_n;
            rd_lo         <= rd_lo_n;
            mack          <= mack_n;
            i2c_sda_t     <= sda_t_n;
            busy          <= busy_n;
            reg_wr_strobe <= strobe_n;
            reg_wr_addr   <= wr_addr_n;
            reg_wr_data   <= wr_data_n;
        end
    end

    // Storage follows the registered strobe, so a commit shows on dbg the clk after.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (reg_wr_strobe && in_range(reg_wr_addr)) begin
            regs[reg_wr_addr[AW-1:0]] <= reg_wr_data;
        end
    end
endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C master, open-drain bus, and a
// register-file model derived from the two-byte CODEC frame rules.
module tb_i2c_codec_responder;
    localparam int Q = 5;
    localparam logic [6:0] DEV = 7'h1A;

    logic       clk = 1'b0;
    logic       reset = 1'b1, scl = 1'b1, m_sda = 1'b1;
    logic       sda_o, sda_t, strobe, busy;
    logic [6:0] wr_addr;
    logic [6:0] dbg_addr = '0;
    logic [8:0] wr_data, dbg_data;
    wire        sda_bus = m_sda & (sda_t | sda_o);

    always #10 clk = ~clk;

    i2c_codec_responder #(.DEVICE_ADDR(DEV), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .i2c_scl_i(scl), .i2c_sda_i(sda_bus),
        .i2c_sda_o(sda_o), .i2c_sda_t(sda_t), .reg_wr_strobe(strobe),
        .reg_wr_addr(wr_addr), .reg_wr_data(wr_data), .dbg_rd_addr(dbg_addr),
        .dbg_rd_data(dbg_data), .busy(busy)
    );

    int          checks = 0, errors = 0, low_cnt = 0;
    logic [15:0] got_q[$], exp_q[$];
    logic [7:0]  txb[$];
    logic [8:0]  mregs [32];
    logic [6:0]  mptr;

    always @(negedge clk) begin
        if (strobe) got_q.push_back({wr_addr, wr_data});
        if (!sda_t) low_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] mread(input logic [6:0] a);
        return (a < 7'd32) ? mregs[a[4:0]] : 9'h000;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q); scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda = b; tick(Q); scl = 1'b1; tick(Q); s = sda_bus; tick(Q); scl = 1'b0; tick(Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        send_bits(b);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(~ack, s);
        m_sda = 1'b1;
    endtask

    task automatic check_strobes(input string tag);
        chk({tag, "_nstb"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) chk({tag, "_stb"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    // Sends txb after the device byte; model applies the frame rules to its own registers.
    task automatic do_write(input logic [6:0] dev, input string tag);
        logic a, hi, own;
        own = (dev == DEV);
        hi  = 1'b0;
        i2c_start();
        send_byte({dev, 1'b0}, a);
        chk({tag, "_dack"}, a, own);
        for (int i = 0; i < txb.size(); i++) begin
            send_byte(txb[i], a);
            chk({tag, "_ack"}, a, own);
            if (own) begin
                if (i % 2 == 0) begin
                    hi   = txb[i][0];
                    mptr = (i == 0) ? txb[i][7:1] : mptr + 7'd1;
                end else begin
                    exp_q.push_back({mptr, hi, txb[i]});
                    if (mptr < 7'd32) mregs[mptr[4:0]] = {hi, txb[i]};
                end
            end
        end
        chk({tag, "_busy"}, busy, own);
        i2c_stop();
        tick(4);
        chk({tag, "_idle"}, {busy, sda_t}, 2'b01);
        check_strobes(tag);
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] b0, input int n, input string tag);
        logic a;
        logic [7:0] d;
        logic [8:0] w;
        i2c_start();
        if (set_ptr) begin
            send_byte({DEV, 1'b0}, a);
            chk({tag, "_wack"}, a, 1'b1);
            send_byte(b0, a);
            chk({tag, "_pack"}, a, 1'b1);
            mptr = b0[7:1];
            i2c_start();
        end
        send_byte({DEV, 1'b1}, a);
        chk({tag, "_rack"}, a, 1'b1);
        for (int k = 0; k < n; k++) begin
            recv_byte(k != n - 1, d);
            w = mread(mptr);
            chk({tag, "_data"}, d, (k % 2 == 0) ? {7'b0, w[8]} : w[7:0]);
            if (k % 2 == 1 && k != n - 1) mptr = mptr + 7'd1;
        end
        i2c_stop();
        tick(4);
        chk({tag, "_idle"}, {busy, sda_t}, 2'b01);
        check_strobes(tag);
    endtask

    task automatic dbg_chk(input logic [6:0] a, input logic [8:0] exp, input string tag);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    initial begin
        int l0, nb;
        logic a;
        logic [6:0] dev, sreg;

        for (int i = 0; i < 32; i++) mregs[i] = 9'h000;
        mptr = 7'd0;

        tick(5);
        chk("rst_sda_t", sda_t, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stb", strobe, 1'b0);
        chk("rst_waddr", wr_addr, 7'd0);
        chk("rst_wdata", wr_data, 9'd0);
        reset = 1'b0;
        tick(4);
        for (int i = 0; i < 32; i++) dbg_chk(7'(i), 9'h000, "rst_reg");
        dbg_chk(7'd100, 9'h000, "rst_oor");

        txb = '{8'h0D, 8'h5A};
        do_write(DEV, "wr6");
        dbg_chk(7'd6, 9'h15A, "wr6_dbg");

        l0 = low_cnt;
        txb = '{8'h0D, 8'h5A, 8'hC3};
        do_write(7'h1B, "ign");
        chk("ign_nodrive", low_cnt - l0, 0);
        dbg_chk(7'd6, 9'h15A, "ign_dbg");

        do_read(1'b1, 8'h0C, 2, "rd6");

        txb = '{8'h3F, 8'hFF, 8'h00, 8'h07};
        do_write(DEV, "wr31");
        dbg_chk(7'd31, 9'h1FF, "wr31_dbg");

        txb = '{8'h0B, 8'h33};
        do_write(DEV, "wr5");
        dbg_chk(7'd5, 9'h133, "wr5_dbg");
        txb = '{8'h0D};
        do_write(DEV, "b1stop");
        dbg_chk(7'd6, 9'h15A, "b1stop_dbg");
        do_read(1'b0, 8'h00, 4, "held");

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                txb.delete();
                nb   = $urandom_range(1, 6);
                sreg = ($urandom_range(0, 7) == 0) ? 7'd126 : 7'($urandom_range(0, 40));
                txb.push_back({sreg, 1'($urandom_range(0, 1))});
                for (int j = 1; j < nb; j++) txb.push_back(8'($urandom));
                dev = DEV;
                if ($urandom_range(0, 4) == 0) begin
                    dev = 7'($urandom);
                    if (dev == DEV) dev = 7'h1B;
                end
                do_write(dev, "rnd_wr");
            end else begin
                do_read(1'($urandom_range(0, 1)), {7'($urandom_range(0, 40)), 1'b0},
                        $urandom_range(1, 5), "rnd_rd");
            end
        end
        for (int i = 0; i < 32; i++) dbg_chk(7'(i), mregs[i], "rnd_reg");

        i2c_start();
        send_byte({DEV, 1'b0}, a);
        send_byte(8'h0D, a);
        send_bits(8'h77);
        chk("ack2_drive", sda_t, 1'b0);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_rel", sda_t, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        tick(3);
        reset = 1'b0;
        scl   = 1'b1;
        m_sda = 1'b1;
        tick(4 * Q);
        check_strobes("mid_rst");
        for (int i = 0; i < 32; i++) dbg_chk(7'(i), 9'h000, "mid_rst_reg");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_codec_responder.md
Name: i2c_codec_responder

Overview:
- I2C slave that emulates the CODEC's internal register file: the far end of the I2C bus driven by the codec controller's I2C master.
- Decodes 7-bit device address, 7-bit register address and 9-bit register data (CODEC two-byte format); ACKs, stores writes, serves reads.
- Used in simulation and on-board loopback to exercise the init sequence and host RD/WR without a physical CODEC.

Parameters:
- DEVICE_ADDR, 7'h1A, 7-bit I2C address answered; all other addresses ignored.
- NUM_REGS, 32, implemented registers (addresses 0..NUM_REGS-1), each 9 bits.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- i2c_scl_i  in  1  SCL line sample
- i2c_sda_i  in  1  SDA line sample
- i2c_sda_o  out  1  SDA drive value, tied 0
- i2c_sda_t  out  1  SDA tristate; 1 = released, 0 = drive low
- reg_wr_strobe  out  1  one-cycle pulse when a register write commits
- reg_wr_addr  out  7  address of committed write
- reg_wr_data  out  9  data of committed write
- dbg_rd_addr  in  7  backdoor read address
- dbg_rd_data  out  9  backdoor read data, combinational
- busy  out  1  high from START (own address matched) to STOP

Behaviour:
- Reset: i2c_sda_t=1, reg_wr_strobe=0, reg_wr_addr=0, reg_wr_data=0, busy=0, all registers 9'h000, state IDLE, register pointer 0.
- SCL/SDA pass through 2-flop synchronizers; edges and START/STOP detected on synchronized values (2-3 clk latency). START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- Data bits sampled on SCL rising edge, MSB first; i2c_sda_t changes only on the clk after SCL falling edge.
- States: IDLE, DEV_ADDR, DEV_ACK, BYTE1, ACK1, BYTE2, ACK2, RD_BYTE, RD_MACK, IGNORE.
- DEV_ADDR: shift 8 bits. Match -> DEV_ACK (drive low for 9th clock), busy=1. Mismatch -> IGNORE (no ACK) until STOP or START.
- Write (R/W=0): BYTE1 = {reg_addr[6:0], data[8]}; ACK1; BYTE2 = data[7:0]; ACK2. Commit occurs at SCL rising edge of the ACK2 bit: register updated, reg_wr_strobe pulses exactly one clk. Address >= NUM_REGS: ACKed, strobe still pulses, storage unchanged.
- Further byte pairs after ACK2: auto-increment pointer (7-bit wrap 127->0), same format without a new address byte.
- STOP/START after BYTE1 before ACK2 completes: no commit, pointer holds BYTE1 address (sets read pointer).
- Read (R/W=1): RD_BYTE shifts out {7'b0, data[8]} then data[7:0] at pointer; release SDA for master ACK bit. Master ACK -> next byte (after second byte, pointer++). Master NACK -> IGNORE until STOP/START. Addresses >= NUM_REGS read 0. Transmitted 1 bits are released (sda_t=1), never driven high.
- Repeated START in any state -> DEV_ADDR; STOP in any state -> IDLE, busy=0, sda_t=1.
- reset asserted mid-transfer: immediate return to reset values including registers; bus released same clk.
- dbg_rd_data = register[dbg_rd_addr] (0 if out of range); a commit is visible the clk after strobe.

Test Plan:
- Reset, idle bus -> sda_t=1, busy=0, dbg_rd_data=0 for addresses 0..31.
- Write dev 0x1A, bytes 0x0D,0x5A (reg 6, data 9'h15A) -> ACK on all 3 bytes, one strobe with addr 6 data 0x15A, dbg_rd_addr=6 gives 0x15A.
- Address 0x1B + byte traffic -> sda_t stays 1 throughout, busy=0, no strobe.
- Write reg 6 = 0x15A; START, 0x34 (1A,W), 0x0C; Sr, 0x35 (1A,R); master ACK then NACK -> bytes 0x01, 0x5A read; STOP returns to IDLE.
- Write 4 bytes starting reg 31: 0x3F,0xFF,0x00,0x07 -> strobes addr 31 data 0x1FF, then addr 32 (out of range, storage unchanged), dbg reg 31 = 0x1FF.
- STOP after BYTE1 only, and reset asserted during ACK2 low phase -> no strobe; on reset sda_t=1 next clk, all registers 0.
